// File: rtl/ysyx_25030093_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_25030093_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } arb_gnt_e;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/ysyx_25030093_arb_timer.sv
// Cycle counter for an in-flight grant; expired marks the LIMIT-th enabled cycle.
module ysyx_25030093_arb_timer
  import ysyx_25030093_arb_pkg::*;
#(
  parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

  // count holds the cycles already spent, so the current cycle is count+1.
  always_comb begin
    expired = 1'b0;
    if (LIMIT != 0) begin
      expired = enable && !clear && (count == 32'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/ysyx_25030093_mem_arb.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter with timeout.
// Define ARB_RR_EN for round-robin conflict resolution; default is fixed LSU priority.
module ysyx_25030093_mem_arb
  import ysyx_25030093_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  // Handshakes: a request transfers on the cycle where valid && ready are both
  // high; ready never rises without the matching valid, and responses are
  // single-cycle pulses the requester must take.

  arb_state_e  state_q, state_d;
  arb_gnt_e    gnt_q, winner;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        wen_q, err_q;
  logic [3:0]  wmask_q;
  logic        accept, in_flight, expired;

`ifdef ARB_RR_EN
  arb_gnt_e last_q;

  always_comb begin
    if (ifu_req_valid && lsu_req_valid) begin
      winner = (last_q == GNT_LSU) ? GNT_IFU : GNT_LSU;
    end else begin
      winner = lsu_req_valid ? GNT_LSU : GNT_IFU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= GNT_IFU;
    end else if (accept) begin
      last_q <= winner;
    end
  end
`else
  always_comb begin
    winner = lsu_req_valid ? GNT_LSU : GNT_IFU;
  end
`endif

  assign accept    = (state_q == ST_IDLE) && rst &&
                     ((winner == GNT_LSU) ? lsu_req_valid : ifu_req_valid);
  assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);

  ysyx_25030093_arb_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_flight),
    .enable  (in_flight),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (expired)            state_d = ST_RESP;
        else if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: if (mem_resp_valid || expired) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = rst && ifu_req_valid && (winner == GNT_IFU);
        lsu_req_ready = rst && lsu_req_valid && (winner == GNT_LSU);
      end
      ST_REQ: mem_req_valid = 1'b1;
      ST_RESP: begin
        ifu_resp_valid = (gnt_q == GNT_IFU);
        lsu_resp_valid = (gnt_q == GNT_LSU);
        rsp_rdata      = rdata_q;
        rsp_err        = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= GNT_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      gnt_q <= winner;
      if (winner == GNT_LSU) begin
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end else begin
        addr_q  <= ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
    end
  end

  // A memory response in WAIT takes precedence over a same-cycle timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == ST_WAIT) && mem_resp_valid) begin
      rdata_q <= mem_rdata;
      err_q   <= mem_resp_err;
    end else if (in_flight && expired) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule
